tdm_frame_deframer: RTL and testbench

Parametrised TDM receive deframer for the serial audio/data front end. It samples a serial TDM stream on `tdm_clk` and locates frames with a one-cycle sync pulse. It de-interleaves `NUM_CH` active slots of `SLOT_BITS` each out of a `FRAME_SLOTS`-slot frame, and presents all channels as a double-buffered, frame-coherent word bank with a one-cycle `frame_valid` strobe. It also flags misplaced sync pulses so the downstream consumer never sees a torn frame.

---
 rtl/tdm_pkg.sv | 10 +
 rtl/tdm_frame_counter.sv | 69 ++++++
 rtl/tdm_frame_deframer.sv | 132 +++++++++++++
 tb/tb_tdm_frame_deframer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared types and width helpers for the TDM receive deframer.
package tdm_pkg;

  typedef enum logic {IDLE, ACTIVE} state_t;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdm_frame_counter.sv
// Bit/slot position tracker for one TDM frame; flags slot ends, commit point and the sync-expected edge.
module tdm_frame_counter
  import tdm_pkg::*;
#(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned FRAME_SLOTS = 8,
  parameter int unsigned SYNC_DELAY  = 0,
  localparam int unsigned SW         = cnt_w(FRAME_SLOTS)
) (
  input  logic          tdm_clk,
  input  logic          reset,
  input  logic          load,
  input  logic          active,
  output logic          sample,
  output logic [SW-1:0] slot_idx,
  output logic          slot_last_bit,
  output logic          frame_last_edge,
  output logic          commit
);

  localparam int unsigned BW = cnt_w(SLOT_BITS);
  localparam logic [BW-1:0] BIT_LAST    = BW'(SLOT_BITS - 1);
  localparam logic [SW-1:0] SLOT_LAST   = SW'(FRAME_SLOTS - 1);
  localparam logic [SW-1:0] COMMIT_SLOT = SW'(NUM_CH - 1);

  logic [BW-1:0] bit_cnt;
  logic [SW-1:0] slot_cnt;
  logic          tail;
  logic          at_bit_last;
  logic          at_frame_last;

  assign at_bit_last   = (bit_cnt == BIT_LAST);
  assign at_frame_last = at_bit_last && (slot_cnt == SLOT_LAST);

  // With no sync delay, edge FRAME_BITS carries no data of this frame; tail marks it.
  assign sample          = active && !tail;
  assign slot_idx        = slot_cnt;
  assign slot_last_bit   = sample && at_bit_last;
  assign commit          = slot_last_bit && (slot_cnt == COMMIT_SLOT);
  assign frame_last_edge = active && ((SYNC_DELAY == 0) ? tail : at_frame_last);

  always_ff @(posedge tdm_clk or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      slot_cnt <= '0;
      tail     <= 1'b0;
    end else if (load) begin
      bit_cnt  <= (SYNC_DELAY == 0) ? BW'(1) : '0;
      slot_cnt <= '0;
      tail     <= 1'b0;
    end else if (sample && !at_frame_last) begin
      tail <= 1'b0;
      if (at_bit_last) begin
        bit_cnt  <= '0;
        slot_cnt <= slot_cnt + SW'(1);
      end else begin
        bit_cnt <= bit_cnt + BW'(1);
      end
    end else if (sample && (SYNC_DELAY == 0)) begin
      tail <= 1'b1;
    end else begin
      bit_cnt  <= '0;
      slot_cnt <= '0;
      tail     <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_frame_deframer.sv
// TDM receive deframer: slot shifter, staging bank, frame-coherent output bank and sync checking.
module tdm_frame_deframer
  import tdm_pkg::*;
#(
  parameter int unsigned NUM_CH      = 5,
  parameter int unsigned SLOT_BITS   = 32,
  parameter int unsigned FRAME_SLOTS = 8,
  parameter int unsigned SYNC_DELAY  = 0,
  parameter int unsigned MSB_FIRST   = 1
) (
  input  logic                        tdm_clk,
  input  logic                        reset,
  input  logic                        tdm_data,
  input  logic                        tdm_sync,
  output logic [NUM_CH*SLOT_BITS-1:0] ch_data,
  output logic                        frame_valid,
  output logic                        sync_err,
  output logic                        in_frame
);

  localparam int unsigned SW = cnt_w(FRAME_SLOTS);

  if (NUM_CH < 1) begin : g_bad_num_ch
    $error("NUM_CH must be at least 1");
  end
  if (SLOT_BITS < 2) begin : g_bad_slot_bits
    $error("SLOT_BITS must be at least 2");
  end
  if (FRAME_SLOTS < NUM_CH) begin : g_bad_frame_slots
    $error("FRAME_SLOTS must be at least NUM_CH");
  end
  if (SYNC_DELAY > 1) begin : g_bad_sync_delay
    $error("SYNC_DELAY must be 0 or 1");
  end
  if (MSB_FIRST > 1) begin : g_bad_msb_first
    $error("MSB_FIRST must be 0 or 1");
  end

  state_t                      state;
  logic                        active;
  logic                        sample;
  logic [SW-1:0]               slot_idx;
  logic                        slot_last_bit;
  logic                        frame_last_edge;
  logic                        commit;
  logic [SLOT_BITS-1:0]        shreg;
  logic [SLOT_BITS-1:0]        shifted;
  logic [SLOT_BITS-1:0]        fresh;
  logic [SLOT_BITS-1:0]        stage [NUM_CH];
  logic [NUM_CH*SLOT_BITS-1:0] bank_next;

  assign active = (state == ACTIVE);

  tdm_frame_counter #(
    .NUM_CH      (NUM_CH),
    .SLOT_BITS   (SLOT_BITS),
    .FRAME_SLOTS (FRAME_SLOTS),
    .SYNC_DELAY  (SYNC_DELAY)
  ) u_counter (
    .tdm_clk         (tdm_clk),
    .reset           (reset),
    .load            (tdm_sync),
    .active          (active),
    .sample          (sample),
    .slot_idx        (slot_idx),
    .slot_last_bit   (slot_last_bit),
    .frame_last_edge (frame_last_edge),
    .commit          (commit)
  );

  if (MSB_FIRST != 0) begin : g_msb_first
    assign shifted = {shreg[SLOT_BITS-2:0], tdm_data};
    assign fresh   = {{(SLOT_BITS-1){1'b0}}, tdm_data};
  end else begin : g_lsb_first
    assign shifted = {tdm_data, shreg[SLOT_BITS-1:1]};
    assign fresh   = {tdm_data, {(SLOT_BITS-1){1'b0}}};
  end

  // The last channel's word is still in the shifter on the commit edge.
  always_comb begin
    bank_next = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      bank_next[k*SLOT_BITS +: SLOT_BITS] = (k == NUM_CH - 1) ? shifted : stage[k];
    end
  end

  always_ff @(posedge tdm_clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      in_frame    <= 1'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      ch_data     <= '0;
      shreg       <= '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        stage[k] <= '0;
      end
    end else begin
      frame_valid <= commit;
      sync_err    <= active && tdm_sync && !frame_last_edge;
      if (commit) begin
        ch_data <= bank_next;
      end
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (slot_last_bit && (slot_idx == SW'(k))) begin
          stage[k] <= shifted;
        end
      end
      // A sync edge restarts the slot; with no delay it already carries bit 0.
      if (tdm_sync) begin
        shreg <= (SYNC_DELAY == 0) ? fresh : '0;
      end else if (sample) begin
        shreg <= shifted;
      end
      case (state)
        IDLE: begin
          if (tdm_sync) begin
            state    <= ACTIVE;
            in_frame <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!tdm_sync && frame_last_edge) begin
            state    <= IDLE;
            in_frame <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tdm_frame_deframer.sv
// Directed bench for tdm_frame_deframer: default, LSB-first and delayed-sync configurations.
module tb_tdm_frame_deframer;

  logic         tdm_clk = 1'b0;
  logic         reset = 1'b1;
  logic         tdm_data = 1'b0;
  logic         tdm_sync = 1'b0;
  logic         d2 = 1'b0;
  logic         s2 = 1'b0;
  logic [159:0] ch0;
  logic [159:0] ch1;
  logic [31:0]  ch2;
  logic         fv0, err0, inf0;
  logic         fv1, err1, inf1;
  logic         fv2, err2, inf2;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  bit           dq[$];
  bit           sq[$];
  int           fv_q[$];
  int           err_q[$];
  int           low_cnt;
  int           low_until;
  int           snap_edge;
  logic [159:0] snap;

  // slot 7 .. slot 0
  localparam logic [255:0] F_A  = {32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h12345678,
                                   32'hFFFFFFFF, 32'h80000000, 32'hDEADBEEF, 32'h00000001};
  localparam logic [255:0] F_B0 = {96'h0, 32'h55555555, 32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
  localparam logic [255:0] F_B1 = {96'h0, 32'hAAAAAAAA, 32'h99999999, 32'h88888888, 32'h77777777, 32'h66666666};
  localparam logic [255:0] F_B2 = {96'h0, 32'h89ABCDEF, 32'h01234567, 32'hFEEDFACE, 32'h0BADC0DE, 32'hCAFEF00D};
  localparam logic [255:0] F_C  = {96'h0, 32'hDDDDDDDD, 32'hDDDDDDDD, 32'hDDDDDDDD, 32'hDDDDDDDD, 32'hDDDDDDDD};
  localparam logic [255:0] F_D  = {96'h0, 32'h11121314, 32'h0D0E0F10, 32'h090A0B0C, 32'h05060708, 32'h01020304};

  always #5 tdm_clk = ~tdm_clk;

  tdm_frame_deframer u_def (
    .tdm_clk(tdm_clk), .reset(reset), .tdm_data(tdm_data), .tdm_sync(tdm_sync),
    .ch_data(ch0), .frame_valid(fv0), .sync_err(err0), .in_frame(inf0)
  );

  tdm_frame_deframer #(.MSB_FIRST(0)) u_lsb (
    .tdm_clk(tdm_clk), .reset(reset), .tdm_data(tdm_data), .tdm_sync(tdm_sync),
    .ch_data(ch1), .frame_valid(fv1), .sync_err(err1), .in_frame(inf1)
  );

  tdm_frame_deframer #(.NUM_CH(2), .SLOT_BITS(16), .FRAME_SLOTS(4), .SYNC_DELAY(1)) u_dly (
    .tdm_clk(tdm_clk), .reset(reset), .tdm_data(d2), .tdm_sync(s2),
    .ch_data(ch2), .frame_valid(fv2), .sync_err(err2), .in_frame(inf2)
  );

  task automatic step(input logic d, input logic s, input logic dd, input logic ss);
    @(negedge tdm_clk);
    tdm_data = d;
    tdm_sync = s;
    d2 = dd;
    s2 = ss;
    @(posedge tdm_clk);
    #1;
  endtask

  task automatic add_frame(input logic [255:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dq.push_back(f[(i / 32) * 32 + 31 - (i % 32)]);
      sq.push_back(i == 0);
    end
  endtask

  task automatic add_idle(input int n);
    for (int i = 0; i < n; i++) begin
      dq.push_back(1'b0);
      sq.push_back(1'b0);
    end
  endtask

  task automatic run_stream();
    fv_q.delete();
    err_q.delete();
    low_cnt = 0;
    for (int e = 0; e < dq.size(); e++) begin
      step(dq[e], sq[e], 1'b0, 1'b0);
      if (fv0) fv_q.push_back(e);
      if (err0) err_q.push_back(e);
      if (!inf0 && e < low_until) low_cnt++;
      if (e == snap_edge) snap = ch0;
    end
    dq.delete();
    sq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge tdm_clk);
    #1;
    total_cnt++;
    if ({ch0, fv0, err0, inf0} !== '0) $display("FAIL reset_def: got ch=%h fv=%b err=%b inf=%b want 0", ch0, fv0, err0, inf0);
    else pass_cnt++;
    total_cnt++;
    if ({ch2, fv2, err2, inf2} !== '0) $display("FAIL reset_dly: got ch=%h fv=%b err=%b inf=%b want 0", ch2, fv2, err2, inf2);
    else pass_cnt++;
    @(negedge tdm_clk);
    reset = 1'b0;
  endtask

  task automatic test_single_frame();
    logic [31:0] exp_m [5];
    logic [31:0] exp_l [5];
    int          first;
    exp_m = '{32'h00000001, 32'hDEADBEEF, 32'h80000000, 32'hFFFFFFFF, 32'h12345678};
    exp_l = '{32'h80000000, 32'hF77DB57B, 32'h00000001, 32'hFFFFFFFF, 32'h1E6A2C48};
    add_frame(F_A, 256);
    add_idle(4);
    low_until = 0;
    snap_edge = -1;
    run_stream();
    first = (fv_q.size() > 0) ? fv_q[0] : -1;
    total_cnt++;
    if (fv_q.size() !== 1) $display("FAIL single_fv_count: got %0d want 1", fv_q.size());
    else pass_cnt++;
    total_cnt++;
    if (first !== 159) $display("FAIL single_fv_edge: got %0d want 159", first);
    else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      total_cnt++;
      if (ch0[k*32 +: 32] !== exp_m[k]) $display("FAIL msb_ch%0d: got %h want %h", k, ch0[k*32 +: 32], exp_m[k]);
      else pass_cnt++;
      total_cnt++;
      if (ch1[k*32 +: 32] !== exp_l[k]) $display("FAIL lsb_ch%0d: got %h want %h", k, ch1[k*32 +: 32], exp_l[k]);
      else pass_cnt++;
    end
    total_cnt++;
    if (err_q.size() !== 0) $display("FAIL single_sync_err: got %0d pulses want 0", err_q.size());
    else pass_cnt++;
    total_cnt++;
    if (inf0 !== 1'b0) $display("FAIL single_idle: got in_frame=%b want 0", inf0);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int got [3];
    int want [3];
    want = '{159, 415, 671};
    add_frame(F_B0, 256);
    add_frame(F_B1, 256);
    add_frame(F_B2, 256);
    add_idle(4);
    low_until = 768;
    snap_edge = 415;
    run_stream();
    total_cnt++;
    if (fv_q.size() !== 3) $display("FAIL b2b_fv_count: got %0d want 3", fv_q.size());
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      got[i] = (fv_q.size() > i) ? fv_q[i] : -1;
      total_cnt++;
      if (got[i] !== want[i]) $display("FAIL b2b_fv_edge%0d: got %0d want %0d", i, got[i], want[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (err_q.size() !== 0) $display("FAIL b2b_sync_err: got %0d pulses want 0", err_q.size());
    else pass_cnt++;
    total_cnt++;
    if (low_cnt !== 0) $display("FAIL b2b_in_frame: got %0d low cycles want 0", low_cnt);
    else pass_cnt++;
    total_cnt++;
    if (snap !== 160'hAAAAAAAA_99999999_88888888_77777777_66666666)
      $display("FAIL b2b_frame1: got %h want AAAAAAAA99999999888888887777777766666666", snap);
    else pass_cnt++;
    total_cnt++;
    if (ch0 !== 160'h89ABCDEF_01234567_FEEDFACE_0BADC0DE_CAFEF00D)
      $display("FAIL b2b_frame2: got %h want 89ABCDEF01234567FEEDFACE0BADC0DECAFEF00D", ch0);
    else pass_cnt++;
  endtask

  task automatic test_sync_error();
    int e0;
    int f0;
    add_frame(F_C, 100);
    add_frame(F_D, 256);
    add_idle(4);
    low_until = 356;
    snap_edge = 200;
    run_stream();
    e0 = (err_q.size() > 0) ? err_q[0] : -1;
    f0 = (fv_q.size() > 0) ? fv_q[0] : -1;
    total_cnt++;
    if (err_q.size() !== 1 || e0 !== 100) $display("FAIL err_pulse: got %0d pulses first %0d want 1 at 100", err_q.size(), e0);
    else pass_cnt++;
    total_cnt++;
    if (fv_q.size() !== 1 || f0 !== 259) $display("FAIL err_fv: got %0d pulses first %0d want 1 at 259", fv_q.size(), f0);
    else pass_cnt++;
    total_cnt++;
    if (snap !== 160'h89ABCDEF_01234567_FEEDFACE_0BADC0DE_CAFEF00D)
      $display("FAIL err_hold: got %h want 89ABCDEF01234567FEEDFACE0BADC0DECAFEF00D", snap);
    else pass_cnt++;
    total_cnt++;
    if (ch0 !== 160'h11121314_0D0E0F10_090A0B0C_05060708_01020304)
      $display("FAIL err_next_frame: got %h want 111213140D0E0F10090A0B0C0506070801020304", ch0);
    else pass_cnt++;
  endtask

  task automatic test_sync_delay();
    logic [63:0] w2;
    int          fv_n;
    int          fv_e;
    int          err_n;
    logic        inf_63;
    logic        inf_64;
    w2 = {16'h0F0F, 16'hFFFF, 16'h1234, 16'hBEEF};
    fv_n = 0;
    fv_e = -1;
    err_n = 0;
    inf_63 = 1'b0;
    inf_64 = 1'b1;
    for (int e = 0; e <= 68; e++) begin
      if (e == 0) step(1'b0, 1'b0, 1'b1, 1'b1);
      else if (e <= 64) step(1'b0, 1'b0, w2[((e - 1) / 16) * 16 + 15 - ((e - 1) % 16)], 1'b0);
      else step(1'b0, 1'b0, 1'b0, 1'b0);
      if (fv2) begin
        fv_n++;
        fv_e = e;
      end
      if (err2) err_n++;
      if (e == 63) inf_63 = inf2;
      if (e == 64) inf_64 = inf2;
    end
    total_cnt++;
    if (fv_n !== 1 || fv_e !== 32) $display("FAIL dly_fv: got %0d pulses last %0d want 1 at 32", fv_n, fv_e);
    else pass_cnt++;
    total_cnt++;
    if (ch2 !== 32'h1234BEEF) $display("FAIL dly_data: got %h want 1234BEEF", ch2);
    else pass_cnt++;
    total_cnt++;
    if (err_n !== 0) $display("FAIL dly_sync_err: got %0d pulses want 0", err_n);
    else pass_cnt++;
    total_cnt++;
    if (inf_63 !== 1'b1 || inf_64 !== 1'b0) $display("FAIL dly_in_frame: got %b%b want 10 at edges 63/64", inf_63, inf_64);
    else pass_cnt++;
  endtask

  task automatic test_reset_midframe();
    int f0;
    add_frame(F_A, 80);
    low_until = 0;
    snap_edge = -1;
    run_stream();
    @(negedge tdm_clk);
    reset = 1'b1;
    #1;
    total_cnt++;
    if ({ch0, fv0, err0, inf0} !== '0) $display("FAIL midreset_out: got ch=%h fv=%b err=%b inf=%b want 0", ch0, fv0, err0, inf0);
    else pass_cnt++;
    @(posedge tdm_clk);
    #1;
    total_cnt++;
    if (fv0 !== 1'b0) $display("FAIL midreset_fv: got %b want 0", fv0);
    else pass_cnt++;
    @(negedge tdm_clk);
    reset = 1'b0;
    add_frame(F_B0, 256);
    add_idle(4);
    run_stream();
    f0 = (fv_q.size() > 0) ? fv_q[0] : -1;
    total_cnt++;
    if (fv_q.size() !== 1 || f0 !== 159) $display("FAIL postreset_fv: got %0d pulses first %0d want 1 at 159", fv_q.size(), f0);
    else pass_cnt++;
    total_cnt++;
    if (ch0 !== 160'h55555555_44444444_33333333_22222222_11111111)
      $display("FAIL postreset_data: got %h want 5555555544444444333333332222222211111111", ch0);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_sync_error();
    test_sync_delay();
    test_reset_midframe();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
